// File: rtl/bcdu_pkg.sv
// Shared BCDU definitions: instruction/digit widths and the packed issue entry.
package bcdu_pkg;

    localparam int BCDU_INSTR_WIDTH       = 16;
    localparam int BCDU_DIGIT_WIDTH       = 4;
    localparam int BCDU_ISSUE_ENTRY_WIDTH = BCDU_INSTR_WIDTH + BCDU_DIGIT_WIDTH;

    // One queued instruction with its companion digit, packed {instr, digit}.
    typedef struct packed {
        logic [BCDU_INSTR_WIDTH-1:0] instr;
        logic [BCDU_DIGIT_WIDTH-1:0] digit;
    } bcdu_issue_entry_t;

    // Builds an issue entry from its two fields.
    function automatic bcdu_issue_entry_t bcdu_pack_entry(
        input logic [BCDU_INSTR_WIDTH-1:0] instr,
        input logic [BCDU_DIGIT_WIDTH-1:0] digit
    );
        bcdu_issue_entry_t e;
        e.instr = instr;
        e.digit = digit;
        return e;
    endfunction

endpackage

// File: rtl/bcdu_sync_fifo.sv
// Synchronous FIFO for BCDU issue entries. Pointers carry one extra wrap bit so
// full and empty are told apart by the MSB compare; storage is never reset.
module bcdu_sync_fifo
    import bcdu_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  bcdu_issue_entry_t i_wr_data,
    input  logic              i_rd_en,
    output bcdu_issue_entry_t o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    bcdu_issue_entry_t  r_mem [DEPTH];

    logic               w_ptr_lsbs_eq;
    logic               w_ptr_msb_eq;

    // NOTE: the array has no reset on purpose; an entry is only ever read after
    // it was written, and the pointers alone define which slots are live.
    // Storage write at the tail slot.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= i_wr_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge value of every other flop, independent of statement order.
    // Pointer update: flush empties the FIFO, otherwise advance on write/pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign w_ptr_lsbs_eq = (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]);
    assign w_ptr_msb_eq  = (r_wr_ptr[PTR_WIDTH] == r_rd_ptr[PTR_WIDTH]);

    assign o_empty   = w_ptr_lsbs_eq && w_ptr_msb_eq;
    assign o_full    = w_ptr_lsbs_eq && !w_ptr_msb_eq;
    assign o_rd_data = r_mem[r_rd_ptr[PTR_WIDTH-1:0]];

endmodule

// File: rtl/bcdu_issue_queue.sv
// BCDU instruction issue queue: FIFO plus a registered output stage that
// offers entries to the controller and holds the last digit after issue.
module bcdu_issue_queue
    import bcdu_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_flush,
    input  logic                        i_valid,
    input  logic [BCDU_INSTR_WIDTH-1:0] i_instr,
    input  logic [BCDU_DIGIT_WIDTH-1:0] i_digit,
    output logic                        o_ready,
    output logic                        o_bcdu_valid,
    output logic [BCDU_INSTR_WIDTH-1:0] o_bcdu_instr,
    output logic [BCDU_DIGIT_WIDTH-1:0] o_bcdu_digit,
    input  logic                        i_bcdu_ready,
    output logic [PTR_WIDTH:0]          o_count,
    output logic                        o_full,
    output logic                        o_idle
);

    // Output stage registers.
    logic                        r_out_valid;
    logic [BCDU_INSTR_WIDTH-1:0] r_out_instr;
    logic [BCDU_DIGIT_WIDTH-1:0] r_out_digit;
    logic [PTR_WIDTH:0]          r_count;

    // Handshake and steering.
    logic                        w_push;
    logic                        w_issue;
    logic                        w_load;
    logic                        w_pop;
    logic                        w_bypass;
    logic                        w_fifo_wr;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    bcdu_issue_entry_t           w_in_entry;
    bcdu_issue_entry_t           w_head_entry;
    bcdu_issue_entry_t           w_load_entry;
    logic                        w_load_valid;

    assign w_in_entry = bcdu_pack_entry(i_instr, i_digit);

    // Acceptance depends on registered FIFO state only, never on i_bcdu_ready.
    assign o_ready = !w_fifo_full && i_rst_n && !i_flush;
    assign w_push  = i_valid && o_ready;
    assign w_issue = r_out_valid && i_bcdu_ready;

    // The output stage may take a new entry when empty or being issued.
    assign w_load = !r_out_valid || w_issue;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    // Output-stage source select: FIFO head first, else bypass, else go empty.
    always_comb begin
        w_pop        = 1'b0;
        w_bypass     = 1'b0;
        w_load_valid = 1'b0;
        w_load_entry = w_head_entry;
        if (w_load) begin
            if (!w_fifo_empty) begin
                w_pop        = 1'b1;
                w_load_valid = 1'b1;
                w_load_entry = w_head_entry;
            end else if (w_push) begin
                w_bypass     = 1'b1;
                w_load_valid = 1'b1;
                w_load_entry = w_in_entry;
            end
        end
    end

    // Anything pushed that did not go straight to the output stage queues up.
    assign w_fifo_wr = w_push && !w_bypass;

    bcdu_sync_fifo #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_flush   (i_flush),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (w_in_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head_entry),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // Output stage: load on free/issue; instr and digit hold when nothing loads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_digit <= '0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_load_valid;
            if (w_load_valid) begin
                r_out_instr <= w_load_entry.instr;
                r_out_digit <= w_load_entry.digit;
            end
        end
    end

    // Occupancy counter covering FIFO plus output stage; flush forces zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_bcdu_valid = r_out_valid;
    assign o_bcdu_instr = r_out_instr;
    assign o_bcdu_digit = r_out_digit;
    assign o_count      = r_count;
    assign o_full       = w_fifo_full;
    assign o_idle       = (r_count == '0) && i_bcdu_ready;

endmodule
